// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage load/store unit on a valid/ready data bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
package mem_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_op;
  } ctrl_t;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] rs2_data_str;
    logic [4:0]  rd_addr;
    ctrl_t       ctrl;
    logic        valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] mem_data;
    logic [4:0]  rd_addr;
    ctrl_t       ctrl;
    logic        valid_mem_wb;
  } mem_wb_reg_t;
endpackage

module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_reg_t       ex_mem_in,
  output logic              stall_o,
  output mem_wb_reg_t       mem_wb_out,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [XLEN/8-1:0] dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rdata,
  input  logic              dmem_rsp_err,
  output logic              fault_o,
  output logic [XLEN-1:0]   fault_addr_o
);
  localparam int NB = XLEN / 8;
  localparam int K  = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (TW > 8) ? TW : 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_n;
  logic [63:0]     lat_addr;
  logic [XLEN-1:0] lat_data;
  logic [4:0]      lat_rd;
  ctrl_t           lat_ctrl;
  logic [CW-1:0]   cnt;

  logic            is_mem, is_st, lat_st, trap, tmo;
  logic [K-1:0]    eff_off;
  logic [NB-1:0]   strb;
  logic [XLEN-1:0] wdata, shifted, ld, ext_mask;
  logic            sign_bit;
  logic [XLEN-1:0] fa_n;
  mem_wb_reg_t     wb_n;
  logic            flt_n, take;
  logic            unused_hi;

  function automatic logic [K-1:0] amask(input logic [1:0] sz);
    return K'((4'd1 << sz) - 4'd1);
  endfunction

  function automatic logic op_ok(input logic [2:0] op, input logic st);
    logic wide;
    wide = (op[1:0] == 2'b11) || (op == 3'b110);
    return (op != 3'b111) && !(st && op[2]) && (!wide || XLEN == 64);
  endfunction

  assign unused_hi = ^ex_mem_in.rs2_data_str;

  assign is_mem = ex_mem_in.ctrl.mem_read || ex_mem_in.ctrl.mem_write;
  assign is_st  = ex_mem_in.ctrl.mem_write && !ex_mem_in.ctrl.mem_read;
  assign lat_st = lat_ctrl.mem_write && !lat_ctrl.mem_read;

  // Illegal widths always fault; misalignment only traps when enabled.
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = !op_ok(ex_mem_in.ctrl.mem_op, is_st) ||
    (|(ex_mem_in.alu_result[K-1:0] &
       amask(ex_mem_in.ctrl.mem_op[1:0])));
`else
  assign trap = !op_ok(ex_mem_in.ctrl.mem_op, is_st);
`endif

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    eff_off  = lat_addr[K-1:0] & ~amask(lat_ctrl.mem_op[1:0]);
    shifted  = dmem_rsp_rdata >> {eff_off, 3'b000};
    strb     = '1;
    wdata    = lat_data;
    ext_mask = '1;
    sign_bit = 1'b0;
    unique case (lat_ctrl.mem_op[1:0])
      2'd0: begin
        strb     = NB'(1);
        wdata    = {NB{lat_data[7:0]}};
        ext_mask = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      2'd1: begin
        strb     = NB'(3);
        wdata    = {(NB/2){lat_data[15:0]}};
        ext_mask = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      2'd2: begin
        strb     = NB'(15);
        wdata    = {(NB/4){lat_data[31:0]}};
        ext_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    strb = strb << eff_off;
    ld   = shifted & ext_mask;
    if (!lat_ctrl.mem_op[2] && sign_bit)
      ld = ld | ~ext_mask;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    flt_n   = 1'b0;
    wb_n    = '0;
    fa_n    = lat_addr[XLEN-1:0];
    unique case (state)
      IDLE: begin
        fa_n = ex_mem_in.alu_result[XLEN-1:0];
        if (ex_mem_in.valid_ex_mem) begin
          if (!is_mem) begin
            wb_n.alu_result   = ex_mem_in.alu_result;
            wb_n.rd_addr      = ex_mem_in.rd_addr;
            wb_n.ctrl         = ex_mem_in.ctrl;
            wb_n.valid_mem_wb = 1'b1;
          end else if (trap) begin
            flt_n = 1'b1;
          end else begin
            take    = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (tmo) begin
          state_n = IDLE;
          flt_n   = 1'b1;
        end else if (dmem_req_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          state_n = IDLE;
          if (dmem_rsp_err) begin
            flt_n = 1'b1;
          end else begin
            wb_n.alu_result   = lat_addr;
            wb_n.rd_addr      = lat_rd;
            wb_n.ctrl         = lat_ctrl;
            wb_n.valid_mem_wb = 1'b1;
            wb_n.mem_data     = lat_st ? '0 : 64'(ld);
          end
        end else if (tmo) begin
          state_n = IDLE;
          flt_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_wb_out   <= '0;
      fault_o      <= 1'b0;
      fault_addr_o <= '0;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_rd       <= '0;
      lat_ctrl     <= '0;
    end else begin
      state      <= state_n;
      mem_wb_out <= wb_n;
      fault_o    <= flt_n;
      if (flt_n)
        fault_addr_o <= fa_n;
      cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
      if (take) begin
        lat_addr <= ex_mem_in.alu_result;
        lat_data <= ex_mem_in.rs2_data_str[XLEN-1:0];
        lat_rd   <= ex_mem_in.rd_addr;
        lat_ctrl <= ex_mem_in.ctrl;
      end
    end
  end

  assign stall_o        = (state != IDLE);
  assign dmem_req_valid = (state == REQ);
  assign dmem_req_we    = dmem_req_valid && lat_st;
  assign dmem_req_addr  = dmem_req_valid ?
    {lat_addr[XLEN-1:K], {K{1'b0}}} : '0;
  assign dmem_req_wdata = dmem_req_we ? wdata : '0;
  assign dmem_req_wstrb = dmem_req_we ? strb : '0;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: random and directed checks of mem_stage_lsu
// against a byte-level memory model.
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;

  localparam int TMO = 12;

  logic        clk = 1'b0;
  logic        reset;
  ex_mem_reg_t ex_mem_in;
  logic        stall_o;
  mem_wb_reg_t mem_wb_out;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid, dmem_rsp_err;
  logic [31:0] dmem_rsp_rdata;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  logic [31:0] rmem [64];
  logic [7:0]  mb   [256];
  int nchk = 0;
  int nerr = 0;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ex_mem_in(ex_mem_in),
    .stall_o(stall_o), .mem_wb_out(mem_wb_out),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_rdata(dmem_rsp_rdata),
    .dmem_rsp_err(dmem_rsp_err), .fault_o(fault_o),
    .fault_addr_o(fault_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_reg_t mk_mem(input bit st,
    input logic [2:0] op, input logic [31:0] addr,
    input logic [31:0] data, input logic [4:0] rd);
    ex_mem_reg_t p;
    p = '0;
    p.alu_result     = {32'h0, addr};
    p.rs2_data_str   = {$urandom, data};
    p.rd_addr        = rd;
    p.ctrl.mem_read  = !st;
    p.ctrl.mem_write = st;
    p.ctrl.reg_write = !st;
    p.ctrl.mem_to_reg = !st;
    p.ctrl.mem_op    = op;
    p.valid_ex_mem   = 1'b1;
    return p;
  endfunction

  function automatic ex_mem_reg_t mk_alu(input logic [31:0] v,
                                         input logic [4:0] rd);
    ex_mem_reg_t p;
    p = '0;
    p.alu_result     = {32'h0, v};
    p.rs2_data_str   = {$urandom, $urandom};
    p.rd_addr        = rd;
    p.ctrl.reg_write = 1'b1;
    p.valid_ex_mem   = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op,
                                             input logic [31:0] addr);
    int n;
    longint v;
    logic [31:0] base;
    n = 1 << op[1:0];
    base = addr & ~(n - 1);
    v = 0;
    for (int b = 0; b < n; b++)
      v |= longint'(mb[(base + b) & 255]) << (8 * b);
    if (!op[2] && v[8*n-1])
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] op,
    input logic [31:0] addr, input logic [31:0] data);
    int n;
    logic [31:0] base;
    n = 1 << op[1:0];
    base = addr & ~(n - 1);
    for (int b = 0; b < n; b++)
      mb[(base + b) & 255] = 8'(data >> (8 * b));
  endtask

  task automatic mem_txn(input bit st, input logic [2:0] op,
    input logic [31:0] addr, input logic [31:0] data,
    input int a, input int w, input bit err);
    int n, stalls, wi;
    logic [31:0] base, e_strb, e_wd, e_ld, cap_wd, nx_alu;
    logic [3:0] cap_strb;
    logic [4:0] rd, nx_rd;
    n = 1 << op[1:0];
    base = addr & ~(n - 1);
    wi = int'(addr[7:2]);
    e_strb = 0;
    e_wd = 0;
    for (int b = 0; b < n; b++)
      e_strb |= 1 << ((base % 4) + b);
    for (int l = 0; l < 4; l++)
      e_wd |= ((data >> (8 * (l % n))) & 32'hFF) << (8 * l);
    e_ld = model_load(op, addr);
    rd = 5'($urandom_range(1, 31));
    nx_rd = 5'($urandom_range(1, 31));
    nx_alu = $urandom;
    cap_wd = 0;
    cap_strb = 0;
    ex_mem_in = mk_mem(st, op, addr, data, rd);
    @(negedge clk);
    ex_mem_in = mk_alu(nx_alu, nx_rd);
    stalls = 0;
    chk("latch_bubble", mem_wb_out.valid_mem_wb, 0);
    for (int i = 0; i <= a; i++) begin
      if (stall_o) stalls++;
      chk("req_valid", dmem_req_valid, 1);
      chk("req_addr", dmem_req_addr, addr & ~32'h3);
      chk("req_we", dmem_req_we, st);
      if (st) begin
        chk("req_wstrb", dmem_req_wstrb, e_strb);
        chk("req_wdata", dmem_req_wdata, e_wd);
      end
      cap_wd = dmem_req_wdata;
      cap_strb = dmem_req_wstrb;
      dmem_req_ready = (i == a);
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    for (int j = 1; j <= w; j++) begin
      if (stall_o) stalls++;
      chk("wait_req_low", dmem_req_valid, 0);
      dmem_rsp_valid = (j == w);
      dmem_rsp_err = err && (j == w);
      dmem_rsp_rdata = (j == w) ? rmem[wi] : $urandom;
      @(negedge clk);
    end
    dmem_rsp_valid = 1'b0;
    dmem_rsp_err = 1'b0;
    chk("stall_cycles", stalls, a + 1 + w);
    chk("stall_release", stall_o, 0);
    if (err) begin
      chk("err_bubble", mem_wb_out.valid_mem_wb, 0);
      chk("err_fault", fault_o, 1);
      chk("err_fault_addr", fault_addr_o, addr);
    end else begin
      chk("wb_valid", mem_wb_out.valid_mem_wb, 1);
      chk("fault_quiet", fault_o, 0);
      chk("wb_addr", mem_wb_out.alu_result, addr);
      chk("wb_rd", mem_wb_out.rd_addr, rd);
      chk("wb_data", mem_wb_out.mem_data, st ? 0 : e_ld);
      if (st) begin
        model_store(op, addr, data);
        for (int l = 0; l < 4; l++)
          if (cap_strb[l]) rmem[wi][8*l +: 8] = cap_wd[8*l +: 8];
      end
    end
    @(negedge clk);
    ex_mem_in = '0;
    chk("held_alu_valid", mem_wb_out.valid_mem_wb, 1);
    chk("held_alu_res", mem_wb_out.alu_result, nx_alu);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls, k;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      rmem[i] = $urandom;
      for (int b = 0; b < 4; b++) mb[4*i+b] = rmem[i][8*b +: 8];
    end
    reset = 1'b1;
    ex_mem_in = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_err = 1'b0;
    dmem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_req_addr", dmem_req_addr, 0);
    chk("rst_req_wdata", dmem_req_wdata, 0);
    chk("rst_req_wstrb", dmem_req_wstrb, 0);
    chk("rst_req_we", dmem_req_we, 0);
    chk("rst_wb_valid", mem_wb_out.valid_mem_wb, 0);
    chk("rst_wb_addr", mem_wb_out.alu_result, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_fault_addr", fault_addr_o, 0);
    reset = 1'b0;

    v = $urandom;
    ex_mem_in = mk_alu(v, 5'd9);
    @(negedge clk);
    ex_mem_in = '0;
    chk("alu_valid", mem_wb_out.valid_mem_wb, 1);
    chk("alu_res", mem_wb_out.alu_result, v);
    chk("alu_rd", mem_wb_out.rd_addr, 9);
    chk("alu_data", mem_wb_out.mem_data, 0);
    chk("alu_nostall", stall_o, 0);
    @(negedge clk);
    chk("bubble", mem_wb_out.valid_mem_wb, 0);

    mem_txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    mem_txn(0, 3'b010, 32'h100, 32'h0, 0, 1, 0);
    mem_txn(1, 3'b010, 32'h100, 32'h80FF7F01, 0, 1, 0);
    mem_txn(0, 3'b000, 32'h103, 32'h0, 0, 1, 0);
    mem_txn(0, 3'b100, 32'h103, 32'h0, 0, 1, 0);
    mem_txn(0, 3'b001, 32'h102, 32'h0, 1, 2, 0);
    mem_txn(1, 3'b000, 32'h101, 32'h000000AB, 0, 1, 0);
    mem_txn(0, 3'b010, 32'h100, 32'h0, 0, 1, 0);
    mem_txn(1, 3'b001, 32'h106, 32'h1234CAFE, 5, 3, 0);
    mem_txn(0, 3'b101, 32'h106, 32'h0, 5, 3, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    ex_mem_in = mk_mem(0, 3'b010, 32'h102, 32'h0, 5'd4);
    @(negedge clk);
    ex_mem_in = '0;
    chk("mis_noreq", dmem_req_valid, 0);
    chk("mis_nostall", stall_o, 0);
    chk("mis_fault", fault_o, 1);
    chk("mis_fault_addr", fault_addr_o, 32'h102);
    chk("mis_bubble", mem_wb_out.valid_mem_wb, 0);
    @(negedge clk);
`else
    mem_txn(0, 3'b010, 32'h102, 32'h0, 0, 1, 0);
`endif

    ex_mem_in = mk_mem(0, 3'b010, 32'h1A4, 32'h0, 5'd7);
    @(negedge clk);
    ex_mem_in = '0;
    stalls = 0;
    k = 0;
    while (!fault_o && k < 40) begin
      if (stall_o) stalls++;
      k++;
      @(negedge clk);
    end
    chk("tmo_fault", fault_o, 1);
    chk("tmo_stalls", stalls, TMO);
    chk("tmo_release", stall_o, 0);
    chk("tmo_req_drop", dmem_req_valid, 0);
    chk("tmo_bubble", mem_wb_out.valid_mem_wb, 0);
    chk("tmo_fault_addr", fault_addr_o, 32'h1A4);
    @(negedge clk);
    chk("tmo_pulse", fault_o, 0);
    mem_txn(0, 3'b000, 32'h1B1, 32'h0, 0, 1, 0);
    chk("fault_addr_hold", fault_addr_o, 32'h1A4);

    mem_txn(0, 3'b010, 32'h108, 32'h0, 1, 2, 1);

    ex_mem_in = mk_mem(0, 3'b010, 32'h140, 32'h0, 5'd3);
    @(negedge clk);
    ex_mem_in = '0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("wait_stall", stall_o, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_req", dmem_req_valid, 0);
    chk("mid_rst_valid", mem_wb_out.valid_mem_wb, 0);
    chk("mid_rst_fault", fault_o, 0);
    v = $urandom;
    ex_mem_in = mk_alu(v, 5'd12);
    @(negedge clk);
    ex_mem_in = '0;
    chk("post_rst_alu", mem_wb_out.valid_mem_wb, 1);
    chk("post_rst_res", mem_wb_out.alu_result, v);

    for (int t = 0; t < 40; t++) begin
      bit st;
      int kk, n;
      logic [2:0] op;
      logic [31:0] addr;
      st = ($urandom % 3) == 0;
      kk = int'($urandom % 5);
      if (st) op = 3'(kk % 3);
      else op = (kk < 3) ? 3'(kk) : 3'(kk + 1);
      n = 1 << op[1:0];
      addr = 32'h100 + ($urandom % 256);
`ifdef MEM_MISALIGN_TRAP_EN
      addr = addr & ~(n - 1);
`endif
      mem_txn(st, op, addr, $urandom, int'($urandom % 5),
              1 + int'($urandom % 5), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised MEM pipeline stage that replaces a single-cycle, always-ready data-memory access with a load/store unit on a valid/ready request/response bus. It sits between the EX/MEM and MEM/WB pipeline registers. It performs byte-lane steering, load sign/zero extension, misalignment detection and response timeout. The pipeline is stalled for the whole memory transaction, and the MEM/WB output is registered.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64. With 64, LD/SD/LWU are legal.
- TIMEOUT_CYCLES, 255: maximum cycles in REQ+WAIT before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_in  in  ex_mem_reg_t  uses `alu_result` (address), `rs2_data_str`, `rd_addr`, `ctrl` (`mem_read`, `mem_write`, `mem_op` = funct3), `valid_ex_mem`.
- stall_o  out  1  hold EX/MEM and all earlier stages.
- mem_wb_out  out  mem_wb_reg_t  registered MEM/WB packet.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  XLEN  address aligned to XLEN/8 bytes.
- dmem_req_wdata  out  XLEN  store data, lane-shifted.
- dmem_req_wstrb  out  XLEN/8  byte enables.
- dmem_rsp_valid  in  1  response valid; always accepted, no ready.
- dmem_rsp_rdata  in  XLEN  full aligned word.
- dmem_rsp_err  in  1  bus error with the response.
- fault_o  out  1  one-cycle pulse on misalign, bus error or timeout.
- fault_addr_o  out  XLEN  offending address; held until the next fault.

## Operation
- FSM states are IDLE, REQ and WAIT.
- IDLE, valid non-memory instruction: the packet is registered into mem_wb_out; mem_data = 0.
- IDLE, valid memory op: latch address, data, mem_op, rd_addr and ctrl. Go to REQ. mem_wb_out.valid_mem_wb = 0 that cycle.
- IDLE, invalid input: emit a bubble (valid_mem_wb = 0).
- REQ: dmem_req_valid = 1. Request fields come from the latch and stay stable until ready. Handshake (valid & ready) moves to WAIT.
- WAIT: on dmem_rsp_valid, write mem_wb_out from the latch, set valid_mem_wb = 1, return to IDLE.
- WAIT, load data: select the byte or half at addr offset, then extend.
  - LB/LH/LW: sign-extend.
  - LBU/LHU/LWU: zero-extend.
  - LD: full 64-bit word.
- Stores: wdata is rs2 replicated or shifted into lanes. wstrb is:
  - SB: 1 bit at addr[k-1:0].
  - SH: 2 bits.
  - SW: 4 bits.
  - SD: all bits.
- A store completes on its write response with valid_mem_wb = 1; mem_data = 0.
- mem_wb_out.alu_result always carries the original, unaligned address.
- stall_o = (state != IDLE).
- While stalled, ex_mem_in is held upstream and is not sampled. It is consumed in the first IDLE cycle.
- A response with dmem_rsp_err = 1 goes to IDLE, pulses fault_o, and emits valid_mem_wb = 0.
- Timeout: an 8+-bit counter clears on leaving IDLE and increments each REQ/WAIT cycle. When count == TIMEOUT_CYCLES-1 without completion:
  - return to IDLE;
  - drop dmem_req_valid;
  - pulse fault_o and emit a bubble.
- A late response arriving in IDLE is ignored.
- Illegal mem_op (e.g. LD with XLEN = 32) is treated as a misaligned access.

## Timing
- Reset values:
  - state = IDLE, stall_o = 0, dmem_req_valid = 0.
  - All other dmem_req_* outputs = 0.
  - mem_wb_out = all zero (valid_mem_wb = 0).
  - fault_o = 0, fault_addr_o = 0, timeout counter = 0.
- Reset mid-transaction aborts the transaction, with no fault. The bench then ignores dmem responses until the next request.
- Non-memory instruction latency: 1 cycle (input at edge N, output valid after edge N+1).
- Memory op timeline: latched at edge N; REQ from N+1; handshake at edge N+1+a; response at edge M ≥ N+2+a; mem_wb_out valid for exactly one cycle after M.
- Zero-wait memory (ready = 1, response the cycle after acceptance) gives 3 cycles of latency and 2 stall cycles.
- dmem_rsp_valid in the same cycle as the handshake is illegal; responses are at least 1 cycle after acceptance.
- fault_o is registered and coincides with the bubble on mem_wb_out.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN`.
- Defined: a half access with addr[0] != 0, or a word/dword access not naturally aligned, is checked in IDLE. The access issues no request, stays in IDLE, pulses fault_o with fault_addr_o = address, and emits a bubble after 1 cycle.
- Undefined: no check is made. Offset bits that would cross a lane boundary are forced to alignment (e.g. LW at 0x1002 reads 0x1000). No fault is raised.

## Test plan
- Zero-wait memory: SW 0xDEADBEEF @0x100, then LW @0x100 → dmem_req_wstrb = 0xF; load mem_data = 0xDEADBEEF; 2 stall cycles per op.
- Memory word 0x80FF7F01: LB @0x3 → 0xFFFFFF80; LBU @0x3 → 0x00000080; LH @0x2 → 0xFFFF80FF; SB 0xAB @0x1 → wstrb = 0x2, wdata = 0xABABABAB.
- ready held low 5 cycles, then response 3 cycles later → dmem_req_addr/wdata stable throughout; stall_o high 9 cycles; one valid output.
- TIMEOUT_CYCLES = 4, no response → fault_o pulse after 4 cycles, fault_addr_o = request address, bubble on output, stall_o released.
- Misalignment:
  - With MEM_MISALIGN_TRAP_EN, LW @0x102 → no dmem_req_valid, fault_o = 1, fault_addr_o = 0x102.
  - Without the macro: request address 0x100.
- Reset asserted in WAIT → next cycle stall_o = 0, dmem_req_valid = 0, valid_mem_wb = 0; a subsequent ADD passes through in 1 cycle.
